// File: rtl/regfile_writeback_queue_if.sv
// -----------------------------------------------------------------------------
// regfile_writeback_queue_if
//
// Bundles the handshake and register-file write signals of the writeback
// queue.
//   s0_*      : producer port 0 (ALU) result handshake
//   s1_*      : producer port 1 (load / multi-cycle) result handshake
//   wb_stall  : hold the queue head this cycle
//   regwe/Rw/Din : register file write port
// Modports:
//   master : producer / register-file side (drives valids, data, wb_stall)
//   slave  : the queue itself
// -----------------------------------------------------------------------------
interface regfile_writeback_queue_if #(
    parameter int AW = 6,
    parameter int DW = 32
) ();
    logic          s0_valid;
    logic [AW-1:0] s0_rd;
    logic [DW-1:0] s0_data;
    logic          s0_ready;

    logic          s1_valid;
    logic [AW-1:0] s1_rd;
    logic [DW-1:0] s1_data;
    logic          s1_ready;

    logic          wb_stall;
    logic          regwe;
    logic [AW-1:0] Rw;
    logic [DW-1:0] Din;

    modport master (
        output s0_valid, s0_rd, s0_data,
        output s1_valid, s1_rd, s1_data,
        output wb_stall,
        input  s0_ready, s1_ready,
        input  regwe, Rw, Din
    );

    modport slave (
        input  s0_valid, s0_rd, s0_data,
        input  s1_valid, s1_rd, s1_data,
        input  wb_stall,
        output s0_ready, s1_ready,
        output regwe, Rw, Din
    );
endinterface

// File: rtl/regfile_writeback_queue.sv
// -----------------------------------------------------------------------------
// regfile_writeback_queue
//
// In-order writeback queue between two result producers and the register
// file. Results from port 0 and port 1 are buffered in a circular FIFO of
// DEPTH entries and drained one per cycle onto the register file write port.
// Optional bypass lookups let decode see pending results before commit.
//
// Optional feature macro: WBQ_BYPASS_EN
//   defined     : ra/rb lookups return the youngest pending matching entry
//   not defined : ra_hit/rb_hit/ra_data/rb_data are tied to 0
//
// Ports:
//   clk      : clock, rising edge
//   reset    : synchronous, active-high; discards all stored entries
//   wbq      : slave side of regfile_writeback_queue_if
//              (s0/s1 handshakes, wb_stall, regwe/Rw/Din)
//   ra, rb   : bypass lookup indices
//   ra_hit, rb_hit   : a pending entry targets ra / rb
//   ra_data, rb_data : data of the youngest pending match
//   count    : entries currently stored
// -----------------------------------------------------------------------------
module regfile_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 6,
    parameter int DW    = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    regfile_writeback_queue_if.slave  wbq,
    input  logic [AW-1:0]             ra,
    input  logic [AW-1:0]             rb,
    output logic                      ra_hit,
    output logic                      rb_hit,
    output logic [DW-1:0]             ra_data,
    output logic [DW-1:0]             rb_data,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head_reg;
    logic [PW-1:0] tail_reg;
    logic [CW-1:0] count_reg;

    logic [AW-1:0] rd_mem   [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    logic [CW-1:0] free;
    logic          s0_ready;
    logic          s1_ready;
    logic          acc0;
    logic          acc1;
    logic          pop;
    logic          not_empty;
    logic [PW-1:0] tail_plus1;
    logic [PW-1:0] s1_slot;
    logic [PW-1:0] head_next;
    logic [PW-1:0] tail_next;
    logic [CW-1:0] count_next;

    // Ready is derived from registered occupancy only, so a pop in the same
    // cycle never opens a slot early. Held low during reset because any
    // handshake in that cycle is dropped.
    assign free      = CW'(DEPTH) - count_reg;
    assign s0_ready  = !reset && (free >= CW'(1));
    assign s1_ready  = !reset && ((free >= CW'(2)) ||
                                  ((free == CW'(1)) && !wbq.s0_valid));
    assign acc0      = wbq.s0_valid && s0_ready;
    assign acc1      = wbq.s1_valid && s1_ready;

    assign not_empty = (count_reg != '0);
    assign pop       = !reset && not_empty && !wbq.wb_stall;

    assign wbq.s0_ready = s0_ready;
    assign wbq.s1_ready = s1_ready;
    assign wbq.regwe    = pop;
    assign wbq.Rw       = (!reset && not_empty) ? rd_mem[head_reg]   : '0;
    assign wbq.Din      = (!reset && not_empty) ? data_mem[head_reg] : '0;
    assign count        = count_reg;

    // Port 0 is older: it takes the tail slot, port 1 follows it.
    assign tail_plus1 = tail_reg + PW'(1);
    assign s1_slot    = acc0 ? tail_plus1 : tail_reg;
    assign tail_next  = tail_reg + PW'(acc0) + PW'(acc1);
    assign head_next  = head_reg + PW'(pop);
    assign count_next = count_reg + CW'(acc0) + CW'(acc1) - CW'(pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Entry storage carries no reset; validity is tracked by head/count.
    always_ff @(posedge clk) begin
        if (acc0) begin
            rd_mem[tail_reg]   <= wbq.s0_rd;
            data_mem[tail_reg] <= wbq.s0_data;
        end
        if (acc1) begin
            rd_mem[s1_slot]    <= wbq.s1_rd;
            data_mem[s1_slot]  <= wbq.s1_data;
        end
    end

`ifdef WBQ_BYPASS_EN
    // Offset gi from head is age order: larger gi is younger. Only the
    // stored entries are scanned; same-cycle incoming results are not.
    // The head being written this cycle stays visible until the edge.
    logic [PW-1:0]    slot_idx [DEPTH];
    logic [DEPTH-1:0] match_a;
    logic [DEPTH-1:0] match_b;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_scan
        logic live;
        assign slot_idx[gi] = head_reg + PW'(gi);
        assign live         = !reset && (CW'(gi) < count_reg);
        assign match_a[gi]  = live && (rd_mem[slot_idx[gi]] == ra);
        assign match_b[gi]  = live && (rd_mem[slot_idx[gi]] == rb);
    end

    always_comb begin
        ra_hit  = 1'b0;
        rb_hit  = 1'b0;
        ra_data = '0;
        rb_data = '0;
        // Later (younger) matches overwrite earlier ones.
        for (int i = 0; i < DEPTH; i++) begin
            if (match_a[i]) begin
                ra_hit  = 1'b1;
                ra_data = data_mem[slot_idx[i]];
            end
            if (match_b[i]) begin
                rb_hit  = 1'b1;
                rb_data = data_mem[slot_idx[i]];
            end
        end
    end
`else
    // Lookup indices are intentionally ignored in this build.
    logic bypass_unused;
    assign bypass_unused = ^{ra, rb};
    assign ra_hit  = 1'b0;
    assign rb_hit  = 1'b0;
    assign ra_data = '0;
    assign rb_data = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// -----------------------------------------------------------------------------
// tb_regfile_writeback_queue
//
// Directed bench for regfile_writeback_queue (DEPTH=4, AW=6, DW=32).
// Stimulus pushes the expected register writes into a scoreboard queue; a
// monitor pops and compares on every regwe. Directed checks cover reset
// state, ready/back-pressure, count, bypass and reset mid-operation.
// -----------------------------------------------------------------------------
module tb_regfile_writeback_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 6;
    localparam int DW    = 32;

`ifdef WBQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wb_t;

    logic            clk;
    logic            reset;
    logic [AW-1:0]   ra;
    logic [AW-1:0]   rb;
    logic            ra_hit;
    logic            rb_hit;
    logic [DW-1:0]   ra_data;
    logic [DW-1:0]   rb_data;
    logic [2:0]      count;

    regfile_writeback_queue_if #(.AW(AW), .DW(DW)) bus ();

    regfile_writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk     (clk),
        .reset   (reset),
        .wbq     (bus),
        .ra      (ra),
        .rb      (rb),
        .ra_hit  (ra_hit),
        .rb_hit  (rb_hit),
        .ra_data (ra_data),
        .rb_data (rb_data),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  n_cmp = 0;
    int  n_err = 0;
    wb_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive(input logic v0, input logic [AW-1:0] rd0, input logic [DW-1:0] d0,
                         input logic v1, input logic [AW-1:0] rd1, input logic [DW-1:0] d1);
        bus.s0_valid = v0;
        bus.s0_rd    = rd0;
        bus.s0_data  = d0;
        bus.s1_valid = v1;
        bus.s1_rd    = rd1;
        bus.s1_data  = d1;
    endtask

    task automatic expect_wb(input logic [AW-1:0] rd, input logic [DW-1:0] data);
        wb_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: every register write must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && bus.regwe) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got Rw=%0d Din=0x%08h expected no write at %0t",
                         bus.Rw, bus.Din, $time);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                chk("wb_rd", 32'(bus.Rw), 32'(e.rd));
                chk("wb_data", bus.Din, e.data);
                $display("write Rw=%0d Din=0x%08h at %0t", bus.Rw, bus.Din, $time);
            end
        end
    end

    // Single-write scenario shared by the first test and the post-reset test.
    task automatic single_write(input string tag, input logic [AW-1:0] rd, input logic [DW-1:0] data);
        ra = rd;
        drive(1'b1, rd, data, 1'b0, '0, '0);
        mid();
        chk({tag, "_s0_ready"}, 32'(bus.s0_ready), 32'd1);
        expect_wb(rd, data);
        cyc();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        mid();
        chk({tag, "_regwe"}, 32'(bus.regwe), 32'd1);
        chk({tag, "_count1"}, 32'(count), 32'd1);
        chk({tag, "_ra_hit"}, 32'(ra_hit), 32'(BYP));
        chk({tag, "_ra_data"}, ra_data, BYP ? data : 32'd0);
        cyc();
        mid();
        chk({tag, "_count0"}, 32'(count), 32'd0);
        chk({tag, "_idle_regwe"}, 32'(bus.regwe), 32'd0);
        chk({tag, "_idle_Rw"}, 32'(bus.Rw), 32'd0);
        chk({tag, "_idle_Din"}, bus.Din, 32'd0);
        chk({tag, "_ra_hit_after"}, 32'(ra_hit), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int mcnt;
        int i;
        int cyc_n;
        bit rdy_exp;
        bit pop_exp;

        reset = 1'b1;
        ra = '0;
        rb = '0;
        bus.wb_stall = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        mid();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_regwe", 32'(bus.regwe), 32'd0);
        chk("rst_Rw", 32'(bus.Rw), 32'd0);
        chk("rst_Din", bus.Din, 32'd0);
        chk("rst_s0_ready", 32'(bus.s0_ready), 32'd1);
        chk("rst_s1_ready", 32'(bus.s1_ready), 32'd1);
        chk("rst_ra_hit", 32'(ra_hit), 32'd0);
        chk("rst_rb_hit", 32'(rb_hit), 32'd0);
        chk("rst_ra_data", ra_data, 32'd0);
        cyc();

        // Test 1: single write
        single_write("t1", 6'd5, 32'hDEADBEEF);

        // Test 2: dual push to the same rd
        cyc();
        rb = 6'd7;
        drive(1'b1, 6'd7, 32'h1, 1'b1, 6'd7, 32'h2);
        mid();
        chk("t2_s0_ready", 32'(bus.s0_ready), 32'd1);
        chk("t2_s1_ready", 32'(bus.s1_ready), 32'd1);
        expect_wb(6'd7, 32'h1);
        expect_wb(6'd7, 32'h2);
        cyc();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        mid();
        chk("t2_count2", 32'(count), 32'd2);
        chk("t2_rb_hit_a", 32'(rb_hit), 32'(BYP));
        chk("t2_rb_data_a", rb_data, BYP ? 32'h2 : 32'h0);
        cyc();
        mid();
        chk("t2_count1", 32'(count), 32'd1);
        chk("t2_rb_data_b", rb_data, BYP ? 32'h2 : 32'h0);
        cyc();
        mid();
        chk("t2_count0", 32'(count), 32'd0);
        chk("t2_rb_hit_c", 32'(rb_hit), 32'd0);

        // Test 3: fill under stall and back-pressure
        cyc();
        bus.wb_stall = 1'b1;
        drive(1'b1, 6'd10, 32'hA0, 1'b1, 6'd11, 32'hA1);
        mid();
        chk("t3_rdy0_a", 32'(bus.s0_ready), 32'd1);
        chk("t3_rdy1_a", 32'(bus.s1_ready), 32'd1);
        expect_wb(6'd10, 32'hA0);
        expect_wb(6'd11, 32'hA1);
        cyc();
        drive(1'b1, 6'd12, 32'hA2, 1'b0, '0, '0);
        mid();
        chk("t3_count2", 32'(count), 32'd2);
        chk("t3_stall_regwe", 32'(bus.regwe), 32'd0);
        expect_wb(6'd12, 32'hA2);
        cyc();
        drive(1'b1, 6'd13, 32'hA3, 1'b1, 6'd14, 32'hA4);
        mid();
        chk("t3_count3", 32'(count), 32'd3);
        chk("t3_rdy0_c3", 32'(bus.s0_ready), 32'd1);
        chk("t3_rdy1_c3", 32'(bus.s1_ready), 32'd0);
        expect_wb(6'd13, 32'hA3);
        cyc();
        drive(1'b1, 6'd15, 32'hA5, 1'b1, 6'd16, 32'hA6);
        mid();
        chk("t3_count4", 32'(count), 32'd4);
        chk("t3_rdy0_full", 32'(bus.s0_ready), 32'd0);
        chk("t3_rdy1_full", 32'(bus.s1_ready), 32'd0);
        cyc();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        bus.wb_stall = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            mid();
            chk("t3_drain_count", 32'(count), 32'(k));
            chk("t3_drain_regwe", 32'(bus.regwe), 32'd1);
            cyc();
        end
        mid();
        chk("t3_empty", 32'(count), 32'd0);

        // Test 4: wrap-around with toggling stall, tracked by an occupancy model
        cyc();
        mcnt  = 0;
        i     = 0;
        cyc_n = 0;
        while (i < 10 && cyc_n < 60) begin
            bus.wb_stall = cyc_n[0];
            drive(1'b1, 6'(i), 32'(i), 1'b0, '0, '0);
            mid();
            rdy_exp = (mcnt < DEPTH);
            pop_exp = (mcnt > 0) && !cyc_n[0];
            chk("t4_count", 32'(count), 32'(mcnt));
            chk("t4_ready", 32'(bus.s0_ready), 32'(rdy_exp));
            chk("t4_regwe", 32'(bus.regwe), 32'(pop_exp));
            if (rdy_exp) begin
                expect_wb(6'(i), 32'(i));
                i++;
            end
            mcnt = mcnt + int'(rdy_exp) - int'(pop_exp);
            cyc();
            cyc_n++;
        end
        if (i < 10) begin
            n_cmp++;
            n_err++;
            $display("FAIL t4_push_budget: got %0d pushes expected 10", i);
        end
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        bus.wb_stall = 1'b0;
        for (int k = 0; k < 2 * DEPTH && mcnt > 0; k++) begin
            mid();
            cyc();
            mcnt--;
        end
        mid();
        chk("t4_count_end", 32'(count), 32'd0);
        chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);

        // Test 5: reset mid-operation
        cyc();
        bus.wb_stall = 1'b1;
        drive(1'b1, 6'd20, 32'hB0, 1'b1, 6'd21, 32'hB1);
        cyc();
        drive(1'b1, 6'd22, 32'hB2, 1'b0, '0, '0);
        cyc();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        mid();
        chk("t5_count3", 32'(count), 32'd3);
        cyc();
        reset = 1'b1;
        bus.wb_stall = 1'b0;
        drive(1'b1, 6'd33, 32'hBAD0, 1'b1, 6'd34, 32'hBAD1);
        mid();
        chk("t5_regwe_in_reset", 32'(bus.regwe), 32'd0);
        chk("t5_Rw_in_reset", 32'(bus.Rw), 32'd0);
        exp_q.delete();
        cyc();
        reset = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        mid();
        chk("t5_count_after", 32'(count), 32'd0);
        chk("t5_regwe_after", 32'(bus.regwe), 32'd0);
        chk("t5_s1_ready_after", 32'(bus.s1_ready), 32'd1);
        repeat (3) cyc();
        single_write("t5", 6'd5, 32'h12345678);

        // Index 0 is an ordinary register
        cyc();
        single_write("t6", 6'd0, 32'hCAFEF00D);

        cyc();
        mid();
        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
